// File: rtl/screen_ram_arbiter.sv
// rtl/screen_ram_arbiter.sv - framebuffer RAM arbiter between CPU bus and VGA scanout
//
// Purpose: shares the single-port 1024-byte framebuffer RAM between one
// outstanding CPU access (one-entry holding register) and VGA scanout reads.
// Video has priority. The CPU is served after at most STARVE_LIMIT
// consecutive video grants.
//
// Ports:
//   CLOCK_50, reset             clock, asynchronous active-high reset
//   cpu_req/addr/rw/wdata       CPU access strobe and its sampled fields
//   cpu_busy/ack/rdata          holding-register state, completion pulse, read data
//   vid_req/addr                scanout level request and RAM address
//   vid_gnt/valid/rdata         grant (combinational), response pulse, read data
//   ram_addr/we/wdata/rdata     framebuffer RAM port (registered read, 1-cycle latency)
//   cpu_stall_cycles            stall statistics counter
//
// Optional feature: define SCREEN_RAM_ARBITER_STATS_EN to build the
// cpu_stall_cycles counter; otherwise the output is tied to zero.

module screen_ram_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h0200,
    parameter int          RAM_DEPTH    = 1024
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        vid_req,
    input  logic [9:0]  vid_addr,
    output logic        vid_gnt,
    output logic        vid_valid,
    output logic [7:0]  vid_rdata,
    output logic [9:0]  ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [15:0] cpu_stall_cycles
);

    // Window bounds are 17 bits so BASE_ADDR+RAM_DEPTH cannot wrap.
    localparam logic [16:0] WIN_LO     = {1'b0, BASE_ADDR};
    localparam logic [16:0] WIN_HI     = 17'(int'(BASE_ADDR) + RAM_DEPTH);
    localparam logic [7:0]  STREAK_MAX = 8'(STARVE_LIMIT);

    logic       busy;
    logic [9:0] hold_addr;
    logic       hold_rw;
    logic [7:0] hold_wdata;
    logic [7:0] streak;
    logic [9:0] ram_addr_q;
    logic       vid_resp;
    logic       cpu_resp;
    logic       cpu_resp_rd;
    logic [7:0] cpu_rdata_q;

    logic accept;
    logic in_range;
    logic cpu_win;
    logic vid_win;

    assign accept   = cpu_req & ~busy;
    assign in_range = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);

    // A request accepted this cycle only becomes eligible next cycle, since
    // busy (the pending flag) is registered.
    assign cpu_win = busy & (~vid_req | (streak == STREAK_MAX));
    assign vid_win = vid_req & ~cpu_win;

    assign vid_gnt   = vid_win;
    assign ram_addr  = cpu_win ? hold_addr : (vid_win ? vid_addr : ram_addr_q);
    assign ram_we    = cpu_win & ~hold_rw;
    assign ram_wdata = hold_wdata;

    assign cpu_busy  = busy;
    assign cpu_ack   = cpu_resp;
    // Read data arrives from the RAM in the ack cycle; pass it through then
    // and hold it afterwards.
    assign cpu_rdata = cpu_resp_rd ? ram_rdata : cpu_rdata_q;
    assign vid_valid = vid_resp;
    assign vid_rdata = vid_resp ? ram_rdata : 8'h00;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            hold_addr   <= '0;
            hold_rw     <= 1'b0;
            hold_wdata  <= '0;
            streak      <= '0;
            ram_addr_q  <= '0;
            vid_resp    <= 1'b0;
            cpu_resp    <= 1'b0;
            cpu_resp_rd <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            // accept needs busy=0 and cpu_win needs busy=1, so they never collide.
            if (accept) begin
                hold_addr  <= 10'(cpu_addr - BASE_ADDR);
                hold_rw    <= cpu_rw;
                hold_wdata <= cpu_wdata;
                busy       <= in_range;
            end else if (cpu_win) begin
                busy <= 1'b0;
            end

            // Out-of-range accesses complete immediately with no RAM cycle.
            cpu_resp    <= cpu_win | (accept & ~in_range);
            cpu_resp_rd <= cpu_win & hold_rw;
            vid_resp    <= vid_win;

            // An out-of-range accept in a read-ack cycle overrides the capture,
            // because its own ack (returning zero) follows next cycle.
            if (accept && !in_range)
                cpu_rdata_q <= 8'h00;
            else if (cpu_resp_rd)
                cpu_rdata_q <= ram_rdata;

            if (!busy || cpu_win)
                streak <= '0;
            else if (vid_win && streak != STREAK_MAX)
                streak <= streak + 8'd1;

            if (cpu_win || vid_win)
                ram_addr_q <= ram_addr;
        end
    end

`ifdef SCREEN_RAM_ARBITER_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (busy && vid_win && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign cpu_stall_cycles = stall_cnt;
`else
    assign cpu_stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// tb/tb_screen_ram_arbiter.sv - self-checking bench for screen_ram_arbiter

module tb_screen_ram_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [9:0]  vid_addr;
    logic        vid_gnt;
    logic        vid_valid;
    logic [7:0]  vid_rdata;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] cpu_stall_cycles;

    int total = 0;
    int bad   = 0;

    logic [7:0] cpu_q[$];
    logic [7:0] vid_q[$];

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        oor;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[9];

    screen_ram_arbiter dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .cpu_req          (cpu_req),
        .cpu_addr         (cpu_addr),
        .cpu_rw           (cpu_rw),
        .cpu_wdata        (cpu_wdata),
        .cpu_busy         (cpu_busy),
        .cpu_ack          (cpu_ack),
        .cpu_rdata        (cpu_rdata),
        .vid_req          (vid_req),
        .vid_addr         (vid_addr),
        .vid_gnt          (vid_gnt),
        .vid_valid        (vid_valid),
        .vid_rdata        (vid_rdata),
        .ram_addr         (ram_addr),
        .ram_we           (ram_we),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .cpu_stall_cycles (cpu_stall_cycles)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] pat(input logic [9:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Registered-read RAM model, preloaded with pat() on the first clock.
    logic [7:0] mem [1024];
    bit         mem_ready;
    always @(posedge CLOCK_50) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(10'(i));
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem_ready ? mem[ram_addr] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected data is queued at stimulus/grant, compared at response.
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (cpu_ack) begin
                if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 1, 0);
                else chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_q.pop_front()});
            end
            if (vid_valid) begin
                if (vid_q.size() == 0) chk("vid_valid_unexpected", 1, 0);
                else chk("vid_rdata", {24'd0, vid_rdata}, {24'd0, vid_q.pop_front()});
            end
            if (vid_gnt) vid_q.push_back(pat(vid_addr));
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b1; cpu_addr = v.addr; cpu_rw = v.rw; cpu_wdata = v.wdata;
        cpu_q.push_back(v.exp_rdata);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        if (v.oor) begin
            chk({tag, "_oor_ack"}, cpu_ack, 1);
            chk({tag, "_oor_busy"}, cpu_busy, 0);
            chk({tag, "_oor_we"}, ram_we, 0);
        end else begin
            chk({tag, "_we"}, ram_we, !v.rw);
            chk({tag, "_addr"}, ram_addr, 10'(v.addr - 16'h0200));
            chk({tag, "_busy"}, cpu_busy, 1);
            chk({tag, "_early_ack"}, cpu_ack, 0);
            if (!v.rw) chk({tag, "_wdata"}, ram_wdata, v.wdata);
            @(negedge CLOCK_50);
            chk({tag, "_ack"}, cpu_ack, 1);
            chk({tag, "_busy_drop"}, cpu_busy, 0);
        end
    endtask

    initial begin
        int   ngnt;
        int   acks;
        logic seen;
        logic hit300;

        vecs[0] = '{16'h0205, 1'b0, 8'h3C, 1'b0, 8'h00};
        vecs[1] = '{16'h0205, 1'b1, 8'h00, 1'b0, 8'h3C};
        vecs[2] = '{16'h05FF, 1'b0, 8'hA5, 1'b0, 8'h3C};
        vecs[3] = '{16'h05FF, 1'b1, 8'h00, 1'b0, 8'hA5};
        vecs[4] = '{16'h0600, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[5] = '{16'h01FF, 1'b0, 8'hEE, 1'b1, 8'h00};
        vecs[6] = '{16'h0200, 1'b0, 8'h11, 1'b0, 8'h00};
        vecs[7] = '{16'h0200, 1'b1, 8'h00, 1'b0, 8'h11};
        vecs[8] = '{16'h0205, 1'b1, 8'h00, 1'b0, 8'h3C};

        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_rw = 1'b0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;

        @(negedge CLOCK_50);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_stall", cpu_stall_cycles, 0);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Starvation: video held, CPU read of $05FF pending.
        @(posedge CLOCK_50); #1;
        vid_req = 1'b1; vid_addr = 10'h020;
        cpu_req = 1'b1; cpu_addr = 16'h05FF; cpu_rw = 1'b1;
        cpu_q.push_back(8'hA5);
        @(negedge CLOCK_50);
        chk("sim_vid_gnt", vid_gnt, 1);
        chk("sim_ram_addr", ram_addr, 10'h020);
        chk("sim_busy", cpu_busy, 0);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        ngnt = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (vid_gnt) ngnt++;
            else if (cpu_busy) begin
                seen = 1'b1;
                chk("starve_cpu_addr", ram_addr, 10'h3FF);
                chk("starve_cpu_we", ram_we, 0);
            end
        end
        chk("starve_cpu_grant_seen", seen, 1);
        chk("starve_vid_gnts", ngnt, 4);
        @(negedge CLOCK_50);
        chk("starve_vid_resume", vid_gnt, 1);
        chk("starve_ack", cpu_ack, 1);
`ifdef SCREEN_RAM_ARBITER_STATS_EN
        chk("starve_stall", cpu_stall_cycles, 4);
`else
        chk("starve_stall", cpu_stall_cycles, 0);
`endif

        // Busy drop: second request while pending must be ignored.
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b1; cpu_addr = 16'h0210; cpu_rw = 1'b0; cpu_wdata = 8'h77;
        cpu_q.push_back(8'hA5);
        @(posedge CLOCK_50); #1;
        cpu_addr = 16'h0300; cpu_wdata = 8'h99;
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        acks = 0; hit300 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (cpu_ack) acks++;
            if (ram_addr == 10'h100) hit300 = 1'b1;
        end
        chk("drop_ack_count", acks, 1);
        chk("drop_addr_300", hit300, 0);
        @(posedge CLOCK_50); #1;
        vid_req = 1'b0;
        run_vec('{16'h0210, 1'b1, 8'h00, 1'b0, 8'h77}, "rb0210");
        run_vec('{16'h0300, 1'b1, 8'h00, 1'b0, pat(10'h100)}, "rb0300");

        // Reset while a CPU access is pending behind video.
        @(posedge CLOCK_50); #1;
        vid_req = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0205; cpu_rw = 1'b1;
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        @(posedge CLOCK_50); #1;
        reset = 1'b1; vid_req = 1'b0;
        @(negedge CLOCK_50);
        chk("mid_rst_busy", cpu_busy, 0);
        chk("mid_rst_ack", cpu_ack, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        chk("mid_rst_vid_valid", vid_valid, 0);
        chk("mid_rst_vid_rdata", vid_rdata, 0);
        chk("mid_rst_vid_gnt", vid_gnt, 0);
        chk("mid_rst_ram_addr", ram_addr, 0);
        chk("mid_rst_ram_we", ram_we, 0);
        chk("mid_rst_ram_wdata", ram_wdata, 0);
        chk("mid_rst_streak", dut.streak, 0);
        chk("mid_rst_stall", cpu_stall_cycles, 0);
        vid_q.delete();
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        repeat (6) @(posedge CLOCK_50);
        #1;
        run_vec('{16'h0205, 1'b1, 8'h00, 1'b0, 8'h3C}, "post_rst");

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("vid_q_empty", vid_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
